// File: rtl/control_sequencer_if.sv
// Purpose : handshake and strobe bundle between control_sequencer and the DataPath/memory model.
// Ports   : run/ir/mem_ready (+step when SINGLE_STEP_EN) toward the sequencer; bus-driver,
//           register-load, ALU select, one-hot GPR strobes and status flags back to the datapath.
// Config  : SINGLE_STEP_EN adds the step input.
interface control_sequencer_if #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
);
  // datapath / memory -> sequencer
  logic             run;
  logic [31:0]      ir;
  logic             mem_ready;
`ifdef SINGLE_STEP_EN
  logic             step;
`endif

  // sequencer -> datapath
  logic             pc_out;
  logic             mdr_out;
  logic             zlow_out;
  logic             zhigh_out;
  logic             mar_in;
  logic             pc_in;
  logic             mdr_in;
  logic             ir_in;
  logic             y_in;
  logic             zlow_in;
  logic             zhigh_in;
  logic             hi_in;
  logic             lo_in;
  logic             inc_pc;
  logic             read;
  logic [OPW-1:0]   alu_op;
  logic [NREGS-1:0] rin;
  logic [NREGS-1:0] rout;
  logic             done;
  logic             halted;
  logic             illegal;

  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  run, ir, mem_ready,
    output pc_out, mdr_out, zlow_out, zhigh_out,
    output mar_in, pc_in, mdr_in, ir_in, y_in,
    output zlow_in, zhigh_in, hi_in, lo_in,
    output inc_pc, read, alu_op, rin, rout,
    output done, halted, illegal
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output run, ir, mem_ready,
    input  pc_out, mdr_out, zlow_out, zhigh_out,
    input  mar_in, pc_in, mdr_in, ir_in, y_in,
    input  zlow_in, zhigh_in, hi_in, lo_in,
    input  inc_pc, read, alu_op, rin, rout,
    input  done, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Purpose : hardwired fetch/execute sequencer for the DataPath (ALU, MUL/DIV, NOP, HALT).
// Latency : 6 cycles per ALU op, 7 per MUL/DIV, 4 per NOP when memory is ready in the first T1 cycle.
// Backpressure: T1 holds Read/MDRin while mem_ready is low; run=0 stops at the next instruction boundary.
//
// Ports:
//   i_clock   - system clock, rising edge
//   i_clear_n - synchronous reset, active-low; overrides everything, even mid-instruction
//   io_ctl    - control_sequencer_if.master: run/ir/mem_ready in, datapath strobes and status out
// Config macro: SINGLE_STEP_EN adds io_ctl.step and a STEP_WAIT state after every retire.
module control_sequencer #(
  parameter int             NREGS   = 16,
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] HALT_OP = OPW'(5'h1B),
  parameter logic [OPW-1:0] NOP_OP  = OPW'(5'h1A)
) (
  input  logic               i_clock,
  input  logic               i_clear_n,
  control_sequencer_if.master io_ctl
);

  localparam logic [OPW-1:0] MUL_OP     = OPW'(5'h0F);
  localparam logic [OPW-1:0] DIV_OP     = OPW'(5'h10);
  localparam logic [OPW-1:0] ALU_OP_MAX = OPW'(5'h08);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_STEP_WAIT,
    S_HALT
  } state_t;

  // Strobes that are a pure function of the next state (plus IR once it is valid).
  typedef struct packed {
    logic pc_out;
    logic mdr_out;
    logic zlow_out;
    logic zhigh_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic zlow_in;
    logic zhigh_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic done;
    logic halted;
  } strb_t;

  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    return {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [OPW-1:0] w_op;
  logic [3:0]     w_ra;
  logic [3:0]     w_rb;
  logic [3:0]     w_rc;
  logic           w_is_nop;
  logic           w_is_halt;
  logic           w_is_muldiv;
  logic           w_is_alu;
  logic           w_is_exec;
  logic           w_unused_ir;

  assign w_op        = io_ctl.ir[31 -: OPW];
  assign w_ra        = io_ctl.ir[26:23];
  assign w_rb        = io_ctl.ir[22:19];
  assign w_rc        = io_ctl.ir[18:15];
  assign w_unused_ir = ^io_ctl.ir[14:0];

  assign w_is_nop    = (w_op == NOP_OP);
  assign w_is_halt   = (w_op == HALT_OP);
  assign w_is_muldiv = (w_op == MUL_OP) || (w_op == DIV_OP);
  assign w_is_alu    = (w_op <= ALU_OP_MAX);
  assign w_is_exec   = w_is_alu || w_is_muldiv;

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t           r_state;
  strb_t            r_strb;
  logic [NREGS-1:0] r_rin;
  logic [NREGS-1:0] r_rout;
  logic [OPW-1:0]   r_alu_op;
  logic             r_illegal;

  state_t           w_next;
  state_t           w_after_done;
  strb_t            w_nxt;
  logic [NREGS-1:0] w_nxt_rin;
  logic [NREGS-1:0] w_nxt_rout;
  logic [OPW-1:0]   w_nxt_alu_op;
  logic             w_set_illegal;

  // Where an instruction goes once it retires.
`ifdef SINGLE_STEP_EN
  assign w_after_done = io_ctl.run ? S_STEP_WAIT : S_IDLE;
`else
  assign w_after_done = io_ctl.run ? S_T0 : S_IDLE;
`endif

  assign w_set_illegal = (r_state == S_T3) && !w_is_nop && !w_is_halt && !w_is_exec;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_ctl.run) w_next = S_T0;
      end
      S_T0: w_next = S_T1;
      S_T1: begin
        if (io_ctl.mem_ready) w_next = S_T2;
      end
      S_T2: w_next = S_T3;
      S_T3: begin
        if (w_is_nop)       w_next = w_after_done;
        else if (w_is_exec) w_next = S_T4;
        else                w_next = S_HALT;   // HALT or undefined opcode
      end
      S_T4: w_next = S_T5;
      S_T5: w_next = w_is_muldiv ? S_T6 : w_after_done;
      S_T6: w_next = w_after_done;
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (!io_ctl.run)      w_next = S_IDLE;
        else if (io_ctl.step) w_next = S_T0;
      end
`else
      S_STEP_WAIT: w_next = S_IDLE;
`endif
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes for the state being entered. IR is only consulted when entering
  // T4/T5, i.e. from T3/T4, where the datapath IR is already latched.
  always_comb begin
    w_nxt        = '0;
    w_nxt_rin    = '0;
    w_nxt_rout   = '0;
    w_nxt_alu_op = '0;
    case (w_next)
      S_T0: begin
        w_nxt.pc_out  = 1'b1;
        w_nxt.mar_in  = 1'b1;
        w_nxt.inc_pc  = 1'b1;
        w_nxt.zlow_in = 1'b1;
      end
      S_T1: begin
        w_nxt.read   = 1'b1;
        w_nxt.mdr_in = 1'b1;
        // PC reload only once; later wait cycles just keep the read open.
        if (r_state != S_T1) begin
          w_nxt.zlow_out = 1'b1;
          w_nxt.pc_in    = 1'b1;
        end
      end
      S_T2: begin
        w_nxt.mdr_out = 1'b1;
        w_nxt.ir_in   = 1'b1;
      end
      S_T4: begin
        w_nxt_rout     = onehot(w_rc);
        w_nxt_alu_op   = w_op;
        w_nxt.zlow_in  = 1'b1;
        w_nxt.zhigh_in = w_is_muldiv;
      end
      S_T5: begin
        w_nxt.zlow_out = 1'b1;
        if (w_is_muldiv) begin
          w_nxt.lo_in = 1'b1;
        end else begin
          w_nxt_rin  = onehot(w_ra);
          w_nxt.done = 1'b1;
        end
      end
      S_T6: begin
        w_nxt.zhigh_out = 1'b1;
        w_nxt.hi_in     = 1'b1;
        w_nxt.done      = 1'b1;
      end
      S_HALT: w_nxt.halted = 1'b1;
      default: w_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_state   <= S_IDLE;
      r_strb    <= '0;
      r_rin     <= '0;
      r_rout    <= '0;
      r_alu_op  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_strb   <= w_nxt;
      r_rin    <= w_nxt_rin;
      r_rout   <= w_nxt_rout;
      r_alu_op <= w_nxt_alu_op;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // IR is loaded on the edge that enters T3, so the T3 decode strobes (Rout[Rb],
  // Yin, NOP Done) cannot be registered ahead of time; they are formed from the
  // registered state and the now-valid IR, and masked while Clear is low.
  logic w_in_t3;
  logic w_t3_exec;

  assign w_in_t3   = i_clear_n && (r_state == S_T3);
  assign w_t3_exec = w_in_t3 && w_is_exec;

  assign io_ctl.pc_out    = r_strb.pc_out;
  assign io_ctl.mdr_out   = r_strb.mdr_out;
  assign io_ctl.zlow_out  = r_strb.zlow_out;
  assign io_ctl.zhigh_out = r_strb.zhigh_out;
  assign io_ctl.mar_in    = r_strb.mar_in;
  assign io_ctl.pc_in     = r_strb.pc_in;
  assign io_ctl.mdr_in    = r_strb.mdr_in;
  assign io_ctl.ir_in     = r_strb.ir_in;
  assign io_ctl.y_in      = w_t3_exec;
  assign io_ctl.zlow_in   = r_strb.zlow_in;
  assign io_ctl.zhigh_in  = r_strb.zhigh_in;
  assign io_ctl.hi_in     = r_strb.hi_in;
  assign io_ctl.lo_in     = r_strb.lo_in;
  assign io_ctl.inc_pc    = r_strb.inc_pc;
  assign io_ctl.read      = r_strb.read;
  assign io_ctl.alu_op    = r_alu_op;
  assign io_ctl.rin       = r_rin;
  assign io_ctl.rout      = r_rout | (w_t3_exec ? onehot(w_rb) : '0);
  assign io_ctl.done      = r_strb.done | (w_in_t3 && w_is_nop);
  assign io_ctl.halted    = r_strb.halted;
  assign io_ctl.illegal   = r_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose : directed, table-driven check of control_sequencer strobe timing per opcode class.
// Latency : expectations are indexed in cycles from the first T0 cycle.
// Backpressure: mem_ready stalls and mid-instruction Clear are covered by hand-written sequences.
module tb_control_sequencer;

  localparam int NREGS = 16;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.NREGS(NREGS), .OPW(5)) ctl ();

  control_sequencer #(
    .NREGS  (NREGS),
    .OPW    (5),
    .HALT_OP(5'h1B),
    .NOP_OP (5'h1A)
  ) dut (
    .i_clock  (clk),
    .i_clear_n(clear_n),
    .io_ctl   (ctl)
  );

  typedef struct packed {
    logic pc_out, mdr_out, zlow_out, zhigh_out, mar_in, pc_in, mdr_in, ir_in, y_in;
    logic zlow_in, zhigh_in, hi_in, lo_in, inc_pc, read, done, halted, illegal;
  } strb_t;

  typedef struct packed {
    strb_t       s;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          done_idx;
    logic [15:0] rout3;
    logic        yin3;
    logic [15:0] rout4;
    logic [4:0]  alu4;
    logic        zh4;
    logic [15:0] rin5;
    logic        lo5;
    logic        hi6;
    logic        ill;
    logic        hlt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.s.pc_out    = ctl.pc_out;
    o.s.mdr_out   = ctl.mdr_out;
    o.s.zlow_out  = ctl.zlow_out;
    o.s.zhigh_out = ctl.zhigh_out;
    o.s.mar_in    = ctl.mar_in;
    o.s.pc_in     = ctl.pc_in;
    o.s.mdr_in    = ctl.mdr_in;
    o.s.ir_in     = ctl.ir_in;
    o.s.y_in      = ctl.y_in;
    o.s.zlow_in   = ctl.zlow_in;
    o.s.zhigh_in  = ctl.zhigh_in;
    o.s.hi_in     = ctl.hi_in;
    o.s.lo_in     = ctl.lo_in;
    o.s.inc_pc    = ctl.inc_pc;
    o.s.read      = ctl.read;
    o.s.done      = ctl.done;
    o.s.halted    = ctl.halted;
    o.s.illegal   = ctl.illegal;
    o.alu         = ctl.alu_op;
    o.rin         = ctl.rin;
    o.rout        = ctl.rout;
    return o;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic vec_t mkv(input string name, input logic [31:0] ir, input int done_idx,
                               input logic [15:0] rout3, input logic yin3,
                               input logic [15:0] rout4, input logic [4:0] alu4, input logic zh4,
                               input logic [15:0] rin5, input logic lo5, input logic hi6,
                               input logic ill, input logic hlt);
    vec_t v;
    v.name = name; v.ir = ir; v.done_idx = done_idx;
    v.rout3 = rout3; v.yin3 = yin3; v.rout4 = rout4; v.alu4 = alu4; v.zh4 = zh4;
    v.rin5 = rin5; v.lo5 = lo5; v.hi6 = hi6; v.ill = ill; v.hlt = hlt;
    return v;
  endfunction

  // Clear low for two edges with run high; returns at a falling edge.
  task automatic do_reset();
    clear_n  = 1'b0;
    ctl.run  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Release Clear and wait (bounded) for the first T0 cycle.
  task automatic start_to_t0(input string name);
    logic found;
    found = 1'b0;
    clear_n = 1'b1;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (ctl.pc_out) found = 1'b1;
    end
    check({name, "_t0_seen"}, 64'(found), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t  vecs[10];
  obs_t  snaps[8];
  strb_t e_t0, e_t1, e_t2;

  initial begin
    obs_t o;
    int   didx, rd, pcin, rdy_idx, irin_idx;
    logic [15:0] rin_any;

    vecs[0] = mkv("shra",    32'h28918000,        5, 16'h0004, 1, 16'h0008, 5'h05, 0, 16'h0002, 0, 0, 0, 0);
    vecs[1] = mkv("add",     mk_ir(5'h00, 5, 5, 7), 5, 16'h0020, 1, 16'h0080, 5'h00, 0, 16'h0020, 0, 0, 0, 0);
    vecs[2] = mkv("sub",     mk_ir(5'h01, 3, 2, 3), 5, 16'h0004, 1, 16'h0008, 5'h01, 0, 16'h0008, 0, 0, 0, 0);
    vecs[3] = mkv("rol",     mk_ir(5'h08, 15, 0, 9), 5, 16'h0001, 1, 16'h0200, 5'h08, 0, 16'h8000, 0, 0, 0, 0);
    vecs[4] = mkv("mul",     mk_ir(5'h0F, 3, 4, 6), 6, 16'h0010, 1, 16'h0040, 5'h0F, 1, 16'h0000, 1, 1, 0, 0);
    vecs[5] = mkv("div",     mk_ir(5'h10, 2, 1, 1), 6, 16'h0002, 1, 16'h0002, 5'h10, 1, 16'h0000, 1, 1, 0, 0);
    vecs[6] = mkv("nop",     mk_ir(5'h1A, 1, 2, 3), 3, 16'h0000, 0, 16'h0000, 5'h00, 0, 16'h0000, 0, 0, 0, 0);
    vecs[7] = mkv("halt",    mk_ir(5'h1B, 4, 5, 6), -1, 16'h0000, 0, 16'h0000, 5'h00, 0, 16'h0000, 0, 0, 0, 1);
    vecs[8] = mkv("ill_1f",  mk_ir(5'h1F, 1, 2, 3), -1, 16'h0000, 0, 16'h0000, 5'h00, 0, 16'h0000, 0, 0, 1, 1);
    vecs[9] = mkv("ill_09",  mk_ir(5'h09, 1, 1, 1), -1, 16'h0000, 0, 16'h0000, 5'h00, 0, 16'h0000, 0, 0, 1, 1);

    e_t0 = '0; e_t0.pc_out = 1; e_t0.mar_in = 1; e_t0.inc_pc = 1; e_t0.zlow_in = 1;
    e_t1 = '0; e_t1.zlow_out = 1; e_t1.pc_in = 1; e_t1.read = 1; e_t1.mdr_in = 1;
    e_t2 = '0; e_t2.mdr_out = 1; e_t2.ir_in = 1;

    ctl.run       = 1'b0;
    ctl.ir        = '0;
    ctl.mem_ready = 1'b1;
`ifdef SINGLE_STEP_EN
    ctl.step      = 1'b1;
`endif

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 10; i++) begin
      ctl.ir        = vecs[i].ir;
      ctl.mem_ready = 1'b1;
      do_reset();
      check({vecs[i].name, "_reset_zero"}, 64'(sample()), 64'(0));
      start_to_t0(vecs[i].name);
      ctl.run  = 1'b0;   // instruction must still complete, then go idle
      snaps[0] = sample();
      for (int k = 1; k < 8; k++) begin
        @(negedge clk);
        snaps[k] = sample();
      end
      didx = -1;
      rin_any = '0;
      for (int k = 0; k < 8; k++) begin
        if (snaps[k].s.done && didx < 0) didx = k;
        rin_any = rin_any | snaps[k].rin;
      end
      check({vecs[i].name, "_t0_strobes"}, 64'(snaps[0].s), 64'(e_t0));
      check({vecs[i].name, "_t1_strobes"}, 64'(snaps[1].s), 64'(e_t1));
      check({vecs[i].name, "_t2_strobes"}, 64'(snaps[2].s), 64'(e_t2));
      check({vecs[i].name, "_done_idx"},   64'(didx),            64'(vecs[i].done_idx));
      check({vecs[i].name, "_rout_t3"},    64'(snaps[3].rout),   64'(vecs[i].rout3));
      check({vecs[i].name, "_yin_t3"},     64'(snaps[3].s.y_in), 64'(vecs[i].yin3));
      check({vecs[i].name, "_rout_t4"},    64'(snaps[4].rout),   64'(vecs[i].rout4));
      check({vecs[i].name, "_alu_t4"},     64'(snaps[4].alu),    64'(vecs[i].alu4));
      check({vecs[i].name, "_zhin_t4"},    64'(snaps[4].s.zhigh_in), 64'(vecs[i].zh4));
      check({vecs[i].name, "_rin_t5"},     64'(snaps[5].rin),    64'(vecs[i].rin5));
      check({vecs[i].name, "_rin_any"},    64'(rin_any),         64'(vecs[i].rin5));
      check({vecs[i].name, "_loin_t5"},    64'(snaps[5].s.lo_in), 64'(vecs[i].lo5));
      check({vecs[i].name, "_hiin_t6"},    64'(snaps[6].s.hi_in), 64'(vecs[i].hi6));
      check({vecs[i].name, "_illegal"},    64'(snaps[7].s.illegal), 64'(vecs[i].ill));
      check({vecs[i].name, "_halted"},     64'(snaps[7].s.halted),  64'(vecs[i].hlt));
      check({vecs[i].name, "_idle_end"},   64'(snaps[7].s.pc_out),  64'(0));
    end

    // ---------------- memory stall: ready low for 3 T1 cycles ----------------
    ctl.ir        = 32'h28918000;
    ctl.mem_ready = 1'b0;
    do_reset();
    start_to_t0("stall");
    ctl.run  = 1'b0;
    rd = 0; pcin = 0; rdy_idx = -1; irin_idx = -1; didx = -1;
    for (int k = 1; k < 14; k++) begin
      @(negedge clk);
      o = sample();
      if (o.s.read)  rd++;
      if (o.s.pc_in) pcin++;
      if (o.s.ir_in && irin_idx < 0) irin_idx = k;
      if (o.s.done && didx < 0) didx = k;
      if (o.s.read && rd == 4) begin
        ctl.mem_ready = 1'b1;
        rdy_idx = k;
      end
    end
    check("stall_read_cycles", 64'(rd),   64'(4));
    check("stall_pcin_cycles", 64'(pcin), 64'(1));
    check("stall_ready_idx",   64'(rdy_idx), 64'(4));
    check("stall_irin_idx",    64'(irin_idx), 64'(5));
    check("stall_done_idx",    64'(didx), 64'(8));

    // ---------------- Clear asserted in T4 ----------------
    ctl.ir        = 32'h28918000;
    ctl.mem_ready = 1'b1;
    do_reset();
    start_to_t0("clr_t4");
    ctl.run = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_t4_in_t4_alu", 64'(ctl.alu_op), 64'(5));
    clear_n = 1'b0;
    @(negedge clk);
    check("clr_t4_all_zero", 64'(sample()), 64'(0));
    clear_n = 1'b1;
    rin_any = '0;
    rd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rin_any = rin_any | ctl.rin;
      if (ctl.pc_out || ctl.done) rd++;
    end
    check("clr_t4_no_rin", 64'(rin_any), 64'(0));
    check("clr_t4_stays_idle", 64'(rd), 64'(0));

    // ---------------- illegal opcode: sticky until Clear ----------------
    ctl.ir = mk_ir(5'h1F, 0, 0, 0);
    do_reset();
    start_to_t0("ill_hold");
    repeat (10) @(negedge clk);   // run left high: HALT must not refetch
    check("ill_hold_illegal", 64'(ctl.illegal), 64'(1));
    check("ill_hold_halted",  64'(ctl.halted),  64'(1));
    check("ill_hold_no_fetch", 64'(ctl.pc_out | ctl.read), 64'(0));
    clear_n = 1'b0;
    ctl.run = 1'b0;
    @(negedge clk);
    check("ill_clear_illegal", 64'(ctl.illegal), 64'(0));
    check("ill_clear_halted",  64'(ctl.halted),  64'(0));

    // ---------------- back-to-back NOPs with run held ----------------
    ctl.ir = mk_ir(5'h1A, 0, 0, 0);
    do_reset();
    start_to_t0("nop_b2b");
    snaps[0] = sample();
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      snaps[k] = sample();
    end
    didx = -1;
    for (int k = 0; k < 8; k++) if (snaps[k].s.done && didx < 0) didx = k;
    check("nop_b2b_done_idx", 64'(didx), 64'(3));
`ifdef SINGLE_STEP_EN
    check("nop_b2b_next_t0", 64'(snaps[5].s), 64'(e_t0));
`else
    check("nop_b2b_next_t0", 64'(snaps[4].s), 64'(e_t0));
`endif
    ctl.run = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
